// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types and helpers for the multi-ported register file.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_sync_if.sv
// ============================================================================
// Module : regfile_mp_sync_if
// Brief  : Read/write port bundle of the multi-ported register file.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_sync_if #(
  parameter int SRAM_INDEX = 6,
  parameter int SRAM_WIDTH = 32,
  parameter int NUM_RD     = 8,
  parameter int NUM_WR     = 4
);
  logic [NUM_RD-1:0]            rd_en_i;
  logic [NUM_RD*SRAM_INDEX-1:0] rd_addr_i;
  logic [NUM_RD*SRAM_WIDTH-1:0] rd_data_o;
  logic [NUM_RD-1:0]            rd_valid_o;
  logic [NUM_WR-1:0]            we_i;
  logic [NUM_WR*SRAM_INDEX-1:0] wr_addr_i;
  logic [NUM_WR*SRAM_WIDTH-1:0] wr_data_i;
  logic                         init_busy_o;
  logic                         wr_conflict_o;

  modport master (
    output rd_en_i, rd_addr_i, we_i, wr_addr_i, wr_data_i,
    input  rd_data_o, rd_valid_o, init_busy_o, wr_conflict_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, we_i, wr_addr_i, wr_data_i,
    output rd_data_o, rd_valid_o, init_busy_o, wr_conflict_o
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module : regfile_wr_arbiter
// Brief  : Per-entry write select; highest-numbered port wins, flags conflicts.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int SRAM_DEPTH = 64,
  parameter int SRAM_INDEX = 6,
  parameter int SRAM_WIDTH = 32,
  parameter int NUM_WR     = 4
) (
  input  wire logic                         i_en,
  input  wire logic [NUM_WR-1:0]            i_we,
  input  wire logic [NUM_WR*SRAM_INDEX-1:0] i_wr_addr,
  input  wire logic [NUM_WR*SRAM_WIDTH-1:0] i_wr_data,
  output logic      [SRAM_DEPTH-1:0]        o_ent_we,
  output logic      [SRAM_WIDTH-1:0]        o_ent_data [SRAM_DEPTH],
  output logic                              o_conflict
);

  // Ascending port scan so a later (higher) port overrides an earlier one.
  // Out-of-range addresses never match an entry, so they drop silently.
  always_comb begin
    o_ent_we   = '0;
    o_conflict = 1'b0;
    for (int e = 0; e < SRAM_DEPTH; e++) begin
      o_ent_data[e] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_en && i_we[w] &&
            (i_wr_addr[w*SRAM_INDEX +: SRAM_INDEX] == SRAM_INDEX'(e))) begin
          if (o_ent_we[e]) begin
            o_conflict = 1'b1;
          end
          o_ent_we[e]   = 1'b1;
          o_ent_data[e] = i_wr_data[w*SRAM_WIDTH +: SRAM_WIDTH];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sync.sv
// ============================================================================
// Module : regfile_mp_sync
// Brief  : NUM_RD-read / NUM_WR-write register file with registered reads and
//          a post-reset clear sequencer. Macro REGFILE_WR_BYPASS_EN enables
//          same-cycle write-to-read bypass.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp_sync
  import regfile_pkg::*;
#(
  parameter int SRAM_DEPTH = 64,
  parameter int SRAM_INDEX = 6,
  parameter int SRAM_WIDTH = 32,
  parameter int NUM_RD     = 8,
  parameter int NUM_WR     = 4
) (
  input wire logic          clk,
  input wire logic          reset,
  regfile_mp_sync_if.slave  bus
);

  localparam int RD_AW  = NUM_RD * SRAM_INDEX;
  localparam int WR_DW  = NUM_WR * SRAM_WIDTH;
  localparam int PTR_W  = (clog2(SRAM_DEPTH) < 1) ? 1 : clog2(SRAM_DEPTH);

  state_t                        r_state;
  logic [PTR_W-1:0]              r_clr_ptr;
  logic [SRAM_WIDTH-1:0]         r_mem [SRAM_DEPTH];
  logic [NUM_RD*SRAM_WIDTH-1:0]  r_rd_data;
  logic [NUM_RD-1:0]             r_rd_valid;
  logic                          r_busy;
  logic                          r_conflict;

  logic [RD_AW-1:0]              w_rd_addr;
  logic [WR_DW-1:0]              w_wr_data;
  logic [SRAM_DEPTH-1:0]         w_ent_we;
  logic [SRAM_WIDTH-1:0]         w_ent_data [SRAM_DEPTH];
  logic                          w_conflict;
  logic [SRAM_WIDTH-1:0]         w_rd_val [NUM_RD];

  assign w_rd_addr = bus.rd_addr_i;
  assign w_wr_data = bus.wr_data_i;

  regfile_wr_arbiter #(
    .SRAM_DEPTH (SRAM_DEPTH),
    .SRAM_INDEX (SRAM_INDEX),
    .SRAM_WIDTH (SRAM_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_wr_arbiter (
    .i_en       (r_state == RUN),
    .i_we       (bus.we_i),
    .i_wr_addr  (bus.wr_addr_i),
    .i_wr_data  (w_wr_data),
    .o_ent_we   (w_ent_we),
    .o_ent_data (w_ent_data),
    .o_conflict (w_conflict)
  );

  // Entry-compare read mux: an address past SRAM_DEPTH matches nothing and reads 0.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_val[p] = '0;
      for (int e = 0; e < SRAM_DEPTH; e++) begin
        if (w_rd_addr[p*SRAM_INDEX +: SRAM_INDEX] == SRAM_INDEX'(e)) begin
`ifdef REGFILE_WR_BYPASS_EN
          w_rd_val[p] = w_ent_we[e] ? w_ent_data[e] : r_mem[e];
`else
          w_rd_val[p] = r_mem[e];
`endif
        end
      end
    end
  end

  // Array has no reset; the INIT sweep defines every entry before first use.
  always_ff @(posedge clk) begin
    for (int e = 0; e < SRAM_DEPTH; e++) begin
      if (r_state == INIT) begin
        if (r_clr_ptr == PTR_W'(e)) begin
          r_mem[e] <= '0;
        end
      end else if (w_ent_we[e]) begin
        r_mem[e] <= w_ent_data[e];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= INIT;
      r_clr_ptr  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_busy     <= 1'b1;
      r_conflict <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_rd_valid <= '0;
          r_conflict <= 1'b0;
          if (r_clr_ptr == PTR_W'(SRAM_DEPTH - 1)) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end else begin
            r_clr_ptr <= r_clr_ptr + PTR_W'(1);
          end
        end
        RUN: begin
          r_conflict <= w_conflict;
          r_rd_valid <= bus.rd_en_i;
          for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_en_i[p]) begin
              r_rd_data[p*SRAM_WIDTH +: SRAM_WIDTH] <= w_rd_val[p];
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bus.rd_data_o     = r_rd_data;
  assign bus.rd_valid_o    = r_rd_valid;
  assign bus.init_busy_o   = r_busy;
  assign bus.wr_conflict_o = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_sync.sv
// ============================================================================
// Module : tb_regfile_mp_sync
// Brief  : Drives a 64-deep and a 48-deep register file with identical stimulus
//          and compares both against an array-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp_sync;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_sync_if #(.SRAM_INDEX(6), .SRAM_WIDTH(32), .NUM_RD(8), .NUM_WR(4)) bus64 ();
  regfile_mp_sync_if #(.SRAM_INDEX(6), .SRAM_WIDTH(32), .NUM_RD(8), .NUM_WR(4)) bus48 ();

  regfile_mp_sync #(.SRAM_DEPTH(64), .SRAM_INDEX(6), .SRAM_WIDTH(32), .NUM_RD(8), .NUM_WR(4))
    u_dut64 (.clk(clk), .reset(reset), .bus(bus64));
  regfile_mp_sync #(.SRAM_DEPTH(48), .SRAM_INDEX(6), .SRAM_WIDTH(32), .NUM_RD(8), .NUM_WR(4))
    u_dut48 (.clk(clk), .reset(reset), .bus(bus48));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  rd_en;
  logic [5:0]  ra [8];
  logic [3:0]  we;
  logic [5:0]  wa [4];
  logic [31:0] wd [4];

  // Reference model, index 0 = 64-deep, index 1 = 48-deep
  int          dep [2] = '{64, 48};
  logic [31:0] mem [2][64];
  bit          run [2];
  int          cnt [2];
  logic [31:0] e_data [2][8];
  logic [7:0]  e_val [2];
  logic        e_conf [2];
  logic        e_busy [2];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; cnt[k] = 0; e_val[k] = '0; e_conf[k] = 1'b0; e_busy[k] = 1'b1;
      for (int p = 0; p < 8; p++) e_data[k][p] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!run[k]) begin
        mem[k][cnt[k]] = '0;
        cnt[k]++;
        if (cnt[k] == dep[k]) begin run[k] = 1; e_busy[k] = 1'b0; end
        e_val[k] = '0; e_conf[k] = 1'b0;
      end else begin
        for (int p = 0; p < 8; p++) begin
          e_val[k][p] = rd_en[p];
          if (rd_en[p]) begin
            logic [31:0] v;
            v = (int'(ra[p]) < dep[k]) ? mem[k][ra[p]] : 32'h0;
`ifdef REGFILE_WR_BYPASS_EN
            for (int w = 0; w < 4; w++)
              if (we[w] && wa[w] == ra[p] && int'(ra[p]) < dep[k]) v = wd[w];
`endif
            e_data[k][p] = v;
          end
        end
        e_conf[k] = 1'b0;
        for (int a = 0; a < dep[k]; a++) begin
          int n = 0;
          for (int w = 0; w < 4; w++) if (we[w] && int'(wa[w]) == a) n++;
          if (n >= 2) e_conf[k] = 1'b1;
        end
        for (int w = 0; w < 4; w++)
          if (we[w] && int'(wa[w]) < dep[k]) mem[k][wa[w]] = wd[w];
      end
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 8; p++) begin
      bus64.rd_addr_i[p*6 +: 6] = ra[p];
      bus48.rd_addr_i[p*6 +: 6] = ra[p];
    end
    for (int w = 0; w < 4; w++) begin
      bus64.wr_addr_i[w*6 +: 6] = wa[w];  bus48.wr_addr_i[w*6 +: 6] = wa[w];
      bus64.wr_data_i[w*32 +: 32] = wd[w]; bus48.wr_data_i[w*32 +: 32] = wd[w];
    end
    bus64.rd_en_i = rd_en; bus48.rd_en_i = rd_en;
    bus64.we_i = we;       bus48.we_i = we;
  endtask

  task automatic cmp_dut(input int k, input string nm, input logic busy, input logic conf,
                         input logic [7:0] val, input logic [255:0] data);
    logic [255:0] ed;
    for (int p = 0; p < 8; p++) ed[p*32 +: 32] = e_data[k][p];
    chk({nm, "_busy"}, {255'h0, busy}, {255'h0, e_busy[k]});
    chk({nm, "_conflict"}, {255'h0, conf}, {255'h0, e_conf[k]});
    chk({nm, "_valid"}, {248'h0, val}, {248'h0, e_val[k]});
    chk({nm, "_data"}, data, ed);
  endtask

  task automatic compare();
    cmp_dut(0, "d64", bus64.init_busy_o, bus64.wr_conflict_o, bus64.rd_valid_o, bus64.rd_data_o);
    cmp_dut(1, "d48", bus48.init_busy_o, bus48.wr_conflict_o, bus48.rd_valid_o, bus48.rd_data_o);
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    if (reset) model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    rd_en = '0; we = '0;
    for (int p = 0; p < 8; p++) ra[p] = '0;
    for (int w = 0; w < 4; w++) begin wa[w] = '0; wd[w] = '0; end
  endtask

  task automatic rand_in();
    rd_en = 8'($urandom); we = 4'($urandom);
    for (int p = 0; p < 8; p++)
      ra[p] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
    for (int w = 0; w < 4; w++) begin
      wa[w] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
      wd[w] = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c64, c48;
    logic [31:0] exp9;
    for (int k = 0; k < 2; k++) for (int a = 0; a < 64; a++) mem[k][a] = '0;
    model_reset();
    idle();
    drive();
    repeat (3) @(posedge clk);
    #1;
    compare();
    reset = 1'b1;

    // Clear sequence with all writes requested during INIT
    c64 = bus64.init_busy_o ? 1 : 0;
    c48 = bus48.init_busy_o ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      rand_in(); we = '1; rd_en = '1;
      step();
      if (bus64.init_busy_o) c64++;
      if (bus48.init_busy_o) c48++;
      if (!bus64.init_busy_o) break;
    end
    chk("init_len64", 256'(c64), 256'd64);
    chk("init_len48", 256'(c48), 256'd48);

    for (int a = 0; a < 64; a += 8) begin
      idle(); rd_en = '1;
      for (int p = 0; p < 8; p++) ra[p] = 6'(a + p);
      step();
      chk("clear_rd64", bus64.rd_data_o, 256'h0);
      chk("clear_val64", {248'h0, bus64.rd_valid_o}, {248'h0, 8'hFF});
    end

    // Basic write then broadcast read
    idle(); we[0] = 1'b1; wa[0] = 6'd5; wd[0] = 32'hDEADBEEF;
    step();
    idle(); rd_en = '1;
    for (int p = 0; p < 8; p++) ra[p] = 6'd5;
    step();
    chk("basic_rw64", bus64.rd_data_o, {8{32'hDEADBEEF}});
    chk("basic_rw48", bus48.rd_data_o, {8{32'hDEADBEEF}});

    // Same-cycle read/write of addr 9
    idle(); we[0] = 1'b1; wa[0] = 6'd9; wd[0] = 32'h11;
    step();
    idle(); we[1] = 1'b1; wa[1] = 6'd9; wd[1] = 32'h22; rd_en[0] = 1'b1; ra[0] = 6'd9;
    step();
`ifdef REGFILE_WR_BYPASS_EN
    exp9 = 32'h22;
`else
    exp9 = 32'h11;
`endif
    chk("rw_same9", {224'h0, bus64.rd_data_o[31:0]}, {224'h0, exp9});
    idle(); rd_en[0] = 1'b1; ra[0] = 6'd9;
    step();
    chk("rw_next9", {224'h0, bus64.rd_data_o[31:0]}, 256'h22);

    // Three-way conflict on addr 12, port 1 to a distinct address
    idle(); we = 4'b1111;
    wa[0] = 6'd12; wd[0] = 32'hA; wa[2] = 6'd12; wd[2] = 32'hB;
    wa[3] = 6'd12; wd[3] = 32'hC; wa[1] = 6'd20; wd[1] = 32'h55;
    step();
    chk("conflict_set", {255'h0, bus64.wr_conflict_o}, 256'h1);
    idle(); rd_en = 8'h03; ra[0] = 6'd12; ra[1] = 6'd20;
    step();
    chk("conflict_clr", {255'h0, bus64.wr_conflict_o}, 256'h0);
    chk("conflict_win", {224'h0, bus64.rd_data_o[31:0]}, 256'hC);
    chk("distinct_wr", {224'h0, bus64.rd_data_o[63:32]}, 256'h55);

    // Out-of-range on the 48-deep array (addr 50 is in range on the 64-deep)
    idle(); we = 4'b0011; wa[0] = 6'd50; wd[0] = 32'h77; wa[1] = 6'd50; wd[1] = 32'h88;
    step();
    chk("oor_noflag48", {255'h0, bus48.wr_conflict_o}, 256'h0);
    chk("oor_flag64", {255'h0, bus64.wr_conflict_o}, 256'h1);
    idle(); rd_en[0] = 1'b1; ra[0] = 6'd50;
    step();
    chk("oor_rd48", {224'h0, bus48.rd_data_o[31:0]}, 256'h0);
    chk("oor_val48", {255'h0, bus48.rd_valid_o[0]}, 256'h1);
    chk("oor_rd64", {224'h0, bus64.rd_data_o[31:0]}, 256'h88);

    for (int i = 0; i < 300; i++) begin
      rand_in();
      step();
    end

    // Reset with reads in flight
    idle(); rd_en = '1;
    for (int p = 0; p < 8; p++) ra[p] = 6'(p + 5);
    step();
    reset = 1'b0;
    #1;
    model_reset();
    compare();
    chk("rst_data64", bus64.rd_data_o, 256'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    for (int i = 0; i < 64; i++) step();
    chk("rst_busy64", {255'h0, bus64.init_busy_o}, 256'h0);
    idle(); rd_en = 8'h1F;
    ra[0] = 6'd5; ra[1] = 6'd9; ra[2] = 6'd12; ra[3] = 6'd20; ra[4] = 6'd50;
    step();
    chk("rst_cleared64", bus64.rd_data_o, 256'h0);
    chk("rst_val64", {248'h0, bus64.rd_valid_o}, {248'h0, 8'h1F});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
